// File: rtl/mc_inj_enc_pkg.sv
// mc_inj_enc_pkg -- shared definitions for the mesh injection encoder.
//
// Global macros (guarded so a second definition site stays harmless):
//   `UADDR / `MADDR : MSB index of the binary / one-hot destination fields
//   `NODEW_P1       : width of a binary node ID
//   `UNICAST / `MULTFWD / `MULTABS : router-side routing codes
//   `DATAW_DEF      : default payload width
//
// Package contents: node count, flit type codes, FSM state type and the
// node-ID to bitmap helper used by the collector.
`ifndef MC_INJ_ENC_DEFINES
`define MC_INJ_ENC_DEFINES
`define UADDR     4
`define MADDR     19
`define NODEW_P1  5
`define UNICAST   2'b00
`define MULTFWD   2'b01
`define MULTABS   2'b10
`define DATAW_DEF 32
`endif

package mc_inj_enc_pkg;

  localparam int NODES = 20;

  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_BODY = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b11;

  typedef enum logic [2:0] {
    S_COLLECT,
    S_ENC,
    S_HEAD,
    S_BODY,
    S_DROP
  } state_e;

  // IDs beyond the mesh shift the single bit out of range and yield 0,
  // so out-of-range destinations simply never reach the bitmap.
  function automatic logic [NODES-1:0] id_to_bit(input logic [`UADDR:0] id);
    logic [NODES-1:0] one;
    one = {{(NODES-1){1'b0}}, 1'b1};
    return one << id;
  endfunction

endpackage

// File: rtl/mc_inj_enc_bmap_enc.sv
// mc_inj_enc_bmap_enc -- combinational destination bitmap classifier.
//
// Ports:
//   bmap    in  20  destination bitmap
//   is_zero out 1   no bit set
//   is_one  out 1   exactly one bit set
//   idx     out 5   binary index of the lowest set bit (0 when bmap is 0)
module mc_inj_enc_bmap_enc
  import mc_inj_enc_pkg::*;
(
  input  logic [NODES-1:0] bmap,
  output logic             is_zero,
  output logic             is_one,
  output logic [`UADDR:0]  idx
);

  always_comb begin
    is_zero = (bmap == '0);
    // Clearing the lowest set bit leaves nothing only for a power of two.
    is_one  = !is_zero && ((bmap & (bmap - {{(NODES-1){1'b0}}, 1'b1})) == '0);
    idx     = '0;
    for (int i = NODES - 1; i >= 0; i--) begin
      if (bmap[i]) idx = (`UADDR+1)'(i);
    end
  end

endmodule

// File: rtl/mc_inj_enc.sv
// mc_inj_enc -- source-side injection encoder for the 5x4 mesh.
//
// Collects destination IDs into a bitmap, encodes a unicast (binary addr0)
// or multicast (one-hot addr1) head flit, then forwards BODY_FLITS payload
// words as body/tail flits. A packet with no valid destination is dropped:
// err_drop pulses and its payload words are consumed silently.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   dst_valid/dst_id/dst_last     destination stream, dst_ready accepts
//   pld_valid/pld_data            payload stream, pld_ready consumes
//   out_valid/out_ready           flit link toward the local router
//   out_ftype/out_um_type         flit type (01/10/11), unicast/multicast
//   out_addr0/out_addr1           head address fields (0 outside head)
//   out_data                      payload (0 outside body/tail)
//   err_drop                      one-cycle pulse on packet abort
//
// Build option: define MC_SELF_FILTER_EN to remove this node's own bit
// from the destination bitmap as IDs are collected.
module mc_inj_enc
  import mc_inj_enc_pkg::*;
#(
  parameter int MY_XPOS    = 0,
  parameter int MY_YPOS    = 0,
  parameter int BODY_FLITS = 4,
  parameter int DATAW      = `DATAW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dst_valid,
  input  logic [`UADDR:0]    dst_id,
  input  logic               dst_last,
  output logic               dst_ready,
  input  logic               pld_valid,
  input  logic [DATAW-1:0]   pld_data,
  output logic               pld_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_ftype,
  output logic               out_um_type,
  output logic [`UADDR:0]    out_addr0,
  output logic [`MADDR:0]    out_addr1,
  output logic [DATAW-1:0]   out_data,
  output logic               err_drop
);

  localparam int         MY_POS   = MY_XPOS * 4 + MY_YPOS;
  localparam logic [3:0] LAST_CNT = 4'(BODY_FLITS - 1);

`ifdef MC_SELF_FILTER_EN
  localparam bit SELF_FILTER = 1'b1;
`else
  localparam bit SELF_FILTER = 1'b0;
`endif

  localparam logic [NODES-1:0] SELF_MASK =
    SELF_FILTER ? ~id_to_bit((`UADDR+1)'(MY_POS)) : {NODES{1'b1}};

  state_e           state, state_nx;
  logic [NODES-1:0] bmap;
  logic [3:0]       cnt;
  logic             err_q;

  logic             um_q;
  logic [`UADDR:0]  addr0_q;
  logic [`MADDR:0]  addr1_q;

  logic             enc_zero;
  logic             enc_one;
  logic [`UADDR:0]  enc_idx;

  logic             flit_hs;
  logic             last_flit;

  mc_inj_enc_bmap_enc u_bmap_enc (
    .bmap    (bmap),
    .is_zero (enc_zero),
    .is_one  (enc_one),
    .idx     (enc_idx)
  );

  assign last_flit = (cnt == LAST_CNT);
  // A payload word is retired on the body link handshake or on any offered
  // word while dropping.
  assign flit_hs   = pld_valid && pld_ready;
  assign err_drop  = err_q;

  always_comb begin
    state_nx    = state;
    dst_ready   = 1'b0;
    pld_ready   = 1'b0;
    out_valid   = 1'b0;
    out_ftype   = 2'b00;
    out_um_type = 1'b0;
    out_addr0   = '0;
    out_addr1   = '0;
    out_data    = '0;
    case (state)
      S_COLLECT: begin
        dst_ready = 1'b1;
        if (dst_valid && dst_last) state_nx = S_ENC;
      end
      S_ENC: begin
        state_nx = enc_zero ? S_DROP : S_HEAD;
      end
      S_HEAD: begin
        out_valid   = 1'b1;
        out_ftype   = FT_HEAD;
        out_um_type = um_q;
        out_addr0   = addr0_q;
        out_addr1   = addr1_q;
        if (out_ready) state_nx = S_BODY;
      end
      S_BODY: begin
        out_valid = pld_valid;
        pld_ready = out_ready;
        out_data  = pld_data;
        out_ftype = last_flit ? FT_TAIL : FT_BODY;
        if (flit_hs && last_flit) state_nx = S_COLLECT;
      end
      S_DROP: begin
        pld_ready = 1'b1;
        if (flit_hs && last_flit) state_nx = S_COLLECT;
      end
      default: state_nx = S_COLLECT;
    endcase
  end

  // Control: state, bitmap, flit counter, drop pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_COLLECT;
      bmap  <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= (state == S_ENC) && enc_zero;
      case (state)
        S_COLLECT: begin
          cnt <= '0;
          if (dst_valid) bmap <= bmap | (id_to_bit(dst_id) & SELF_MASK);
        end
        S_HEAD: cnt <= '0;
        S_BODY, S_DROP: begin
          if (flit_hs) begin
            if (last_flit) begin
              cnt  <= '0;
              bmap <= '0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Head fields, captured in ENC and held through HEAD
  always_ff @(posedge clk) begin
    if (state == S_ENC) begin
      um_q    <= !enc_one;
      addr0_q <= enc_one ? enc_idx : '0;
      addr1_q <= enc_one ? '0 : bmap;
    end
  end

endmodule

// File: tb/tb_mc_inj_enc.sv
module tb_mc_inj_enc;

  localparam int BF     = 4;
  localparam int MY_POS = 0;
`ifdef MC_SELF_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        dst_valid;
  logic [4:0]  dst_id;
  logic        dst_last;
  logic        dst_ready;
  logic        pld_valid;
  logic [31:0] pld_data;
  logic        pld_ready;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ftype;
  logic        out_um_type;
  logic [4:0]  out_addr0;
  logic [19:0] out_addr1;
  logic [31:0] out_data;
  logic        err_drop;

  mc_inj_enc #(
    .MY_XPOS(0), .MY_YPOS(0), .BODY_FLITS(BF), .DATAW(32)
  ) dut (
    .clk(clk), .rst(rst),
    .dst_valid(dst_valid), .dst_id(dst_id), .dst_last(dst_last), .dst_ready(dst_ready),
    .pld_valid(pld_valid), .pld_data(pld_data), .pld_ready(pld_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_ftype(out_ftype),
    .out_um_type(out_um_type), .out_addr0(out_addr0), .out_addr1(out_addr1),
    .out_data(out_data), .err_drop(err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Link-side ready generation
  int   rdy_mode = 0;   // 0 always ready, 1 random, 2 manual
  logic rdy_rand = 1'b1;
  logic rdy_manual = 1'b1;
  assign out_ready = (rdy_mode == 2) ? rdy_manual : rdy_rand;

  always @(posedge clk) begin
    #1;
    rdy_rand = (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Flit monitor
  typedef struct {
    logic [1:0]  ft;
    logic        um;
    logic [4:0]  a0;
    logic [19:0] a1;
    logic [31:0] d;
  } flit_t;

  flit_t       obs[$];
  flit_t       mf;
  int          drop_cnt = 0;
  bit          hold_pend = 1'b0;
  logic [59:0] prev_f;
  logic [59:0] cur_f;

  always @(negedge clk) begin
    cur_f = {out_ftype, out_um_type, out_addr0, out_addr1, out_data};
    if (!rst && hold_pend) chk("hold_stable", {out_valid, cur_f}, {1'b1, prev_f});
    hold_pend = !rst && out_valid && !out_ready;
    prev_f = cur_f;
    if (err_drop) drop_cnt++;
    if (!rst && out_valid && out_ready) begin
      mf.ft = out_ftype; mf.um = out_um_type; mf.a0 = out_addr0;
      mf.a1 = out_addr1; mf.d = out_data;
      obs.push_back(mf);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Bounded wait for dst_ready (is_pld=0) or pld_ready (is_pld=1) at a negedge
  task automatic wait_ready(input bit is_pld, output bit got);
    got = 1'b0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (is_pld ? pld_ready : dst_ready) begin
        got = 1'b1;
        return;
      end
    end
  endtask

  task automatic drive_dsts(input int n, input int ids[8]);
    bit got;
    for (int i = 0; i < n; i++) begin
      dst_valid = 1'b1;
      dst_id    = 5'(ids[i]);
      dst_last  = (i == n - 1);
      wait_ready(1'b0, got);
      if (!got) begin
        chk("dst_timeout", 0, 1);
        dst_valid = 1'b0; dst_last = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    dst_valid = 1'b0;
    dst_last  = 1'b0;
  endtask

  task automatic drive_pld(input logic [31:0] words[BF], input int nw, input bit bubbles);
    bit got;
    for (int k = 0; k < nw; k++) begin
      if (bubbles && $urandom_range(0, 2) == 0) begin
        pld_valid = 1'b0;
        @(posedge clk); #1;
      end
      pld_valid = 1'b1;
      pld_data  = words[k];
      wait_ready(1'b1, got);
      if (!got) begin
        chk("pld_timeout", 0, 1);
        pld_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    pld_valid = 1'b0;
  endtask

  task automatic run_pkt(input string tag, input int n, input int ids[8],
                         input logic [31:0] words[BF], input bit bubbles,
                         input bit e_drop, input bit e_um,
                         input logic [4:0] e_a0, input logic [19:0] e_a1);
    int exp_n;
    obs.delete();
    drop_cnt = 0;
    drive_dsts(n, ids);
    @(negedge clk);
    chk({tag, "_enc_cycle"}, {out_valid, dst_ready}, 2'b00);
    @(negedge clk);
    chk({tag, "_head_latency"}, {out_valid, err_drop, dst_ready}, {!e_drop, e_drop, 1'b0});
    @(posedge clk); #1;
    drive_pld(words, BF, bubbles);
    @(negedge clk);
    chk({tag, "_next_dst_ready"}, dst_ready, 1'b1);
    exp_n = e_drop ? 0 : 1 + BF;
    chk({tag, "_flit_count"}, obs.size(), exp_n);
    chk({tag, "_drop_pulses"}, drop_cnt, e_drop ? 1 : 0);
    if (obs.size() == exp_n && !e_drop) begin
      chk({tag, "_head"}, {obs[0].ft, obs[0].um, obs[0].a0, obs[0].a1, obs[0].d},
          {2'b01, e_um, e_a0, e_a1, 32'd0});
      for (int k = 0; k < BF; k++)
        chk({tag, "_body"}, {obs[k+1].ft, obs[k+1].um, obs[k+1].a0, obs[k+1].a1, obs[k+1].d},
            {(k == BF - 1) ? 2'b11 : 2'b10, 1'b0, 5'd0, 20'd0, words[k]});
    end
    @(posedge clk); #1;
  endtask

  // Reference: destinations form a set of mesh nodes; the header form
  // follows from how many distinct nodes remain.
  task automatic model(input int n, input int ids[8], output bit drop, output bit um,
                       output logic [4:0] a0, output logic [19:0] a1);
    bit hit[20];
    int count;
    int lowest;
    for (int j = 0; j < 20; j++) hit[j] = 1'b0;
    for (int i = 0; i < n; i++)
      if (ids[i] < 20 && !(FILT && ids[i] == MY_POS)) hit[ids[i]] = 1'b1;
    count = 0; lowest = -1; a1 = '0;
    for (int j = 0; j < 20; j++)
      if (hit[j]) begin
        count++;
        if (lowest < 0) lowest = j;
        a1 = a1 + (20'd1 << j);
      end
    drop = (count == 0);
    um   = (count >= 2);
    a0   = (count == 1) ? 5'(lowest) : 5'd0;
    if (count < 2) a1 = '0;
  endtask

  typedef struct {
    int          n;
    int          ids[8];
    bit          drop;
    bit          um;
    logic [4:0]  a0;
    logic [19:0] a1;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input int n, input int i0, input int i1, input int i2, input int i3,
                         input bit d, input bit u, input logic [4:0] a0, input logic [19:0] a1);
    vec_t v;
    v.n = n;
    for (int j = 0; j < 8; j++) v.ids[j] = 0;
    v.ids[0] = i0; v.ids[1] = i1; v.ids[2] = i2; v.ids[3] = i3;
    v.drop = d; v.um = u; v.a0 = a0; v.a1 = a1;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] w[BF];
    int          ids[8];
    bit          got;
    bit          e_drop, e_um;
    logic [4:0]  e_a0;
    logic [19:0] e_a1;
    logic [1:0]  hft[5];

    add_vec(1, 13, 0, 0, 0,  1'b0, 1'b0, 5'd13, 20'h0);
    add_vec(3, 5, 9, 18, 0,  1'b0, 1'b1, 5'd0,  20'h40220);
    add_vec(3, 7, 7, 25, 0,  1'b0, 1'b0, 5'd7,  20'h0);
    add_vec(1, 0, 0, 0, 0,   FILT, 1'b0, 5'd0,  20'h0);
    add_vec(2, 0, 19, 0, 0,  1'b0, !FILT, FILT ? 5'd19 : 5'd0, FILT ? 20'h0 : 20'h80001);
    add_vec(1, 19, 0, 0, 0,  1'b0, 1'b0, 5'd19, 20'h0);
    add_vec(1, 31, 0, 0, 0,  1'b1, 1'b0, 5'd0,  20'h0);
    add_vec(4, 3, 3, 3, 3,   1'b0, 1'b0, 5'd3,  20'h0);

    rst = 1'b1; dst_valid = 1'b0; dst_id = '0; dst_last = 1'b0;
    pld_valid = 1'b0; pld_data = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_state", {dst_ready, pld_ready, out_valid, err_drop, out_addr0, out_addr1, out_data},
        {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 20'd0, 32'd0});
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven packets
    foreach (tbl[t]) begin
      for (int k = 0; k < BF; k++) w[k] = 32'hA000_0000 + 32'(t * 16 + k);
      run_pkt($sformatf("vec%0d", t), tbl[t].n, tbl[t].ids, w, 1'b0,
              tbl[t].drop, tbl[t].um, tbl[t].a0, tbl[t].a1);
    end

    // Back-pressure: 5 stalled cycles on the head and on the 2nd body flit
    for (int j = 0; j < 8; j++) ids[j] = 0;
    ids[0] = 13;
    for (int k = 0; k < BF; k++) w[k] = 32'hB000_0000 + 32'(k);
    rdy_mode = 2; rdy_manual = 1'b0;
    obs.delete();
    drive_dsts(1, ids);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_head", {out_valid, out_ftype, out_addr0}, {1'b1, 2'b01, 5'd13});
      @(posedge clk); #1;
    end
    rdy_manual = 1'b1;
    @(posedge clk); #1;
    pld_valid = 1'b1; pld_data = w[0];
    @(posedge clk); #1;
    pld_data = w[1]; rdy_manual = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_body", {out_valid, out_ftype, out_data, pld_ready}, {1'b1, 2'b10, w[1], 1'b0});
      @(posedge clk); #1;
    end
    rdy_manual = 1'b1;
    @(posedge clk); #1;
    pld_data = w[2];
    @(posedge clk); #1;
    pld_data = w[3];
    @(posedge clk); #1;
    pld_valid = 1'b0;
    @(negedge clk);
    chk("hold_flit_count", obs.size(), 5);
    hft[0] = 2'b01; hft[1] = 2'b10; hft[2] = 2'b10; hft[3] = 2'b10; hft[4] = 2'b11;
    if (obs.size() == 5)
      for (int k = 0; k < 5; k++)
        chk("hold_seq", {obs[k].ft, obs[k].d}, {hft[k], (k == 0) ? 32'd0 : w[k-1]});
    rdy_mode = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset during the 3rd body flit cycle
    obs.delete();
    drive_dsts(1, ids);
    for (int k = 0; k < 2; k++) begin
      pld_valid = 1'b1; pld_data = w[k];
      wait_ready(1'b1, got);
      if (!got) chk("rst_pld_timeout", 0, 1);
      @(posedge clk); #1;
    end
    pld_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_packet", {out_valid, dst_ready, pld_ready, err_drop}, 4'b0100);
    chk("rst_pre_flits", obs.size(), 3);
    @(posedge clk); #1;
    ids[0] = 6;
    for (int k = 0; k < BF; k++) w[k] = 32'hC000_0000 + 32'(k);
    run_pkt("after_rst", 1, ids, w, 1'b0, 1'b0, 1'b0, 5'd6, 20'h0);

    // Randomized packets against the reference model
    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int j = 0; j < 8; j++) ids[j] = (j < n) ? $urandom_range(0, 24) : 0;
      for (int k = 0; k < BF; k++) w[k] = $urandom;
      model(n, ids, e_drop, e_um, e_a0, e_a1);
      run_pkt($sformatf("rnd%0d", p), n, ids, w, 1'b1, e_drop, e_um, e_a0, e_a1);
    end
    rdy_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_inj_enc.md
Name: mc_inj_enc

Overview:
- Source-side injection encoder in the network interface of each node in the 5x4 mesh.
- Collects a stream of destination node IDs into a 20-bit destination bitmap.
- Picks the address form for the header:
  - exactly one destination: unicast, binary addr0;
  - two or more destinations: multicast, one-hot addr1.
- Emits a head flit followed by BODY_FLITS payload flits on a valid/ready link to the local router input port.
- Produces the um_type/addr0/addr1 fields that every router's decode stage consumes.

Parameters:
- MY_XPOS, 0, X coordinate of this node (0..4).
- MY_YPOS, 0, Y coordinate of this node (0..3). Node position is MY_POS = MY_XPOS*4 + MY_YPOS.
- BODY_FLITS, 4, payload flits per packet (1..15); the last one is typed tail.
- DATAW, 32, payload width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- dst_valid  in  1  destination ID offered.
- dst_id  in  5  destination node ID (x*4+y).
- dst_last  in  1  final destination of this packet.
- dst_ready  out  1  destination accepted this cycle.
- pld_valid  in  1  payload word offered.
- pld_data  in  DATAW  payload word.
- pld_ready  out  1  payload word consumed.
- out_valid  out  1  flit valid toward router.
- out_ready  in  1  router accepts flit.
- out_ftype  out  2  flit type: 01 head, 10 body, 11 tail.
- out_um_type  out  1  0 unicast, 1 multicast (head only).
- out_addr0  out  `UADDR+1  binary destination (unicast head only, else 0).
- out_addr1  out  `MADDR+1  one-hot destination bitmap (multicast head only, else 0).
- out_data  out  DATAW  payload (body/tail only, else 0).
- err_drop  out  1  one-cycle pulse when a packet is aborted.

Behaviour:
- Reset (synchronous, active-high) takes effect at the next rising clk edge and forces:
  - state COLLECT, bitmap 0, flit counter 0;
  - dst_ready 1, pld_ready 0, out_valid 0, err_drop 0;
  - all address and data outputs 0.
- Reset mid-packet aborts without emitting a tail; the router side is expected to be reset together with this block.

State machine:
- COLLECT
  - dst_ready = 1.
  - Each dst_valid cycle ORs bit dst_id into the bitmap. Duplicate IDs are idempotent.
  - dst_id >= 20 is ignored; the packet still proceeds.
  - A handshake with dst_last = 1 moves the FSM to ENC.
- ENC (one cycle)
  - dst_ready = 0.
  - The bmap_enc sub-block computes popcount==0, popcount==1 and the binary index of the lowest set bit.
  - Head fields are registered from its result:
    - count 1: um_type 0, addr0 = index, addr1 = 0.
    - count >= 2: um_type 1, addr0 = 0, addr1 = bitmap.
    - count 0: go to DROP.
  - Otherwise go to HEAD.
- HEAD
  - out_valid = 1, ftype 01.
  - Fields stay stable while out_valid && !out_ready.
  - On out_ready, go to BODY with the counter at 0.
- BODY
  - Combinational pass-through: out_valid = pld_valid, pld_ready = out_ready, out_data = pld_data.
  - ftype is 11 when counter == BODY_FLITS-1, else 10.
  - The counter increments on each handshake.
  - After the tail handshake, clear the bitmap and return to COLLECT.
  - The payload source must hold its word stable until accepted.
- DROP
  - err_drop pulses in the first DROP cycle.
  - pld_ready = 1; BODY_FLITS payload words are consumed and discarded with out_valid = 0.
  - Then clear the bitmap and return to COLLECT.

Timing:
- Latency: dst_last accepted at edge T, head out_valid asserted after edge T+1 (visible in cycle T+1..T+2 window, i.e. 2 cycles after the last destination request).
- Throughput: the next packet's destinations are accepted in the cycle after the tail handshake.

Boundary rules:
- out_ready held low: head or body is held indefinitely; no flit is duplicated or skipped.
- pld_valid low in BODY: the bubble is passed through as out_valid 0.
- dst_valid during ENC/HEAD/BODY/DROP: not accepted, since dst_ready = 0.

Optional Feature:
- Macro: MC_SELF_FILTER_EN.
- Defined: bit MY_POS is masked out of the bitmap on entry.
  - A packet whose only destination was this node becomes count 0 and goes to DROP with err_drop.
  - Self plus one other destination becomes unicast.
- Undefined: the self bit is kept. The local router absorbs it (unicast to self, or multicast absorb-and-forward at the source).

Decomposition:
- Shared define.h holds:
  - `UADDR, `MADDR, `NODEW_P1;
  - node count 20;
  - flit type codes HEAD/BODY/TAIL;
  - the UNICAST/MULTFWD/MULTABS codes;
  - the DATAW default.
- One sub-module, bmap_enc: purely combinational 20-bit popcount-class (0/1/many) plus lowest-set-bit binary encoder.

Test Plan:
- Node (0,0), single dst_id 13 with last -> head: um_type 0, addr0 5'd13, addr1 0; 4 payload words emitted as ftypes 10,10,10,11.
- dst_ids 5, 9, 18 then last -> head: um_type 1, addr1 20'h40220, addr0 0; data matches payload order.
- dst_ids 7, 7, 25 (last) -> unicast: addr0 7; ID 25 ignored; no err_drop.
- Only dst_id 0 at node (0,0) with MC_SELF_FILTER_EN defined -> err_drop pulse, 4 payload words consumed, out_valid never 1; without the macro -> unicast head with addr0 0.
- out_ready low 5 cycles during head and during the 2nd body flit -> outputs stable, exactly 5 flits total, no duplicates.
- rst asserted in the 3rd body flit cycle -> next cycle out_valid 0, dst_ready 1, bitmap 0; a following unicast packet encodes correctly.
